// File: rtl/tl_ul_pkg.sv
// -----------------------------------------------------------------------------
// tl_ul_pkg
// Shared TileLink-UL definitions for the channel buffer slice:
//   - bus width constants
//   - A/D channel opcode encodings
//   - packed A-channel and D-channel beat structs used as FIFO payloads
// -----------------------------------------------------------------------------
package tl_ul_pkg;

  localparam int TL_AW     = 30;
  localparam int TL_DW     = 32;
  localparam int TL_SRCW   = 7;
  localparam int TL_SZW    = 3;
  localparam int TL_MASKW  = 4;
  localparam int TL_OPW    = 3;
  localparam int TL_APARW  = 3;
  localparam int TL_DPARW  = 2;
  localparam int TL_SINKW  = 1;

  // A-channel opcodes
  localparam logic [TL_OPW-1:0] PutFull       = 3'd0;
  localparam logic [TL_OPW-1:0] PutPartial    = 3'd1;
  localparam logic [TL_OPW-1:0] Get           = 3'd4;
  // D-channel opcodes
  localparam logic [TL_OPW-1:0] AccessAck     = 3'd0;
  localparam logic [TL_OPW-1:0] AccessAckData = 3'd1;

  typedef struct packed {
    logic [TL_OPW-1:0]   opcode;
    logic [TL_APARW-1:0] param;
    logic [TL_SZW-1:0]   size;
    logic [TL_SRCW-1:0]  source;
    logic [TL_AW-1:0]    address;
    logic [TL_MASKW-1:0] mask;
    logic [TL_DW-1:0]    data;
    logic                corrupt;
  } tl_a_t;

  typedef struct packed {
    logic [TL_OPW-1:0]   opcode;
    logic [TL_DPARW-1:0] param;
    logic [TL_SZW-1:0]   size;
    logic [TL_SRCW-1:0]  source;
    logic [TL_SINKW-1:0] sink;
    logic                denied;
    logic [TL_DW-1:0]    data;
    logic                corrupt;
  } tl_d_t;

endpackage

// File: rtl/tl_ul_fifo.sv
// -----------------------------------------------------------------------------
// tl_ul_fifo
// Generic circular FIFO with valid/ready on both sides. Ready and valid depend
// only on the registered occupancy count (plus the reset pin), so no
// combinational path exists from enqueue side to dequeue side or back.
// A beat written at edge N is visible at o_deq_* in cycle N+1 (no flow-through).
// Ports:
//   i_clock, i_rst_n                 clock, async active-low reset
//   i_enq_valid/o_enq_ready/i_enq_data   write side
//   o_deq_valid/i_deq_ready/o_deq_data   read side
//   o_empty                          occupancy is zero
// -----------------------------------------------------------------------------
module tl_ul_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             i_clock,
  input  logic             i_rst_n,
  input  logic             i_enq_valid,
  output logic             o_enq_ready,
  input  logic [WIDTH-1:0] i_enq_data,
  output logic             o_deq_valid,
  input  logic             i_deq_ready,
  output logic [WIDTH-1:0] o_deq_data,
  output logic             o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] COUNT_ZERO = CW'(0);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             w_enq;
  logic             w_deq;

  // Ready is held low while reset is asserted, then rises straight from count==0.
  assign o_enq_ready = i_rst_n & (r_count != COUNT_FULL);
  assign o_deq_valid = (r_count != COUNT_ZERO);
  assign o_empty     = (r_count == COUNT_ZERO);
  assign o_deq_data  = r_mem[r_rd_ptr];

  assign w_enq = i_enq_valid & o_enq_ready;
  assign w_deq = o_deq_valid & i_deq_ready;

  // Pointer and occupancy state; pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + COUNT_ONE;
        2'b01:   r_count <= r_count - COUNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage; intentionally not reset, contents are ignored while empty.
  always_ff @(posedge i_clock) begin
    if (w_enq) begin
      r_mem[r_wr_ptr] <= i_enq_data;
    end
  end

endmodule

// File: rtl/tl_ul_channel_buffer.sv
// -----------------------------------------------------------------------------
// tl_ul_channel_buffer
// Registered TileLink-UL buffer stage between the master-side crossbar (in_*)
// and the pass-through adapter (out_*). A requests flow in_a -> out_a, D
// responses flow out_d -> in_d, each through its own FIFO.
// Ports:
//   clock, reset                 clock, async active-low reset
//   in_a_*  / out_a_*            A channel, master side / adapter side
//   out_d_* / in_d_*             D channel, adapter side / master side
//   idle                         both FIFOs empty
// -----------------------------------------------------------------------------
module tl_ul_channel_buffer
  import tl_ul_pkg::*;
#(
  parameter int A_DEPTH = 2,
  parameter int D_DEPTH = 2
) (
  input  logic                clock,
  input  logic                reset,

  input  logic                in_a_valid,
  output logic                in_a_ready,
  input  logic [TL_OPW-1:0]   in_a_opcode,
  input  logic [TL_APARW-1:0] in_a_param,
  input  logic [TL_SZW-1:0]   in_a_size,
  input  logic [TL_SRCW-1:0]  in_a_source,
  input  logic [TL_AW-1:0]    in_a_address,
  input  logic [TL_MASKW-1:0] in_a_mask,
  input  logic [TL_DW-1:0]    in_a_data,
  input  logic                in_a_corrupt,

  output logic                out_a_valid,
  input  logic                out_a_ready,
  output logic [TL_OPW-1:0]   out_a_opcode,
  output logic [TL_APARW-1:0] out_a_param,
  output logic [TL_SZW-1:0]   out_a_size,
  output logic [TL_SRCW-1:0]  out_a_source,
  output logic [TL_AW-1:0]    out_a_address,
  output logic [TL_MASKW-1:0] out_a_mask,
  output logic [TL_DW-1:0]    out_a_data,
  output logic                out_a_corrupt,

  input  logic                out_d_valid,
  output logic                out_d_ready,
  input  logic [TL_OPW-1:0]   out_d_opcode,
  input  logic [TL_DPARW-1:0] out_d_param,
  input  logic [TL_SZW-1:0]   out_d_size,
  input  logic [TL_SRCW-1:0]  out_d_source,
  input  logic [TL_SINKW-1:0] out_d_sink,
  input  logic                out_d_denied,
  input  logic [TL_DW-1:0]    out_d_data,
  input  logic                out_d_corrupt,

  output logic                in_d_valid,
  input  logic                in_d_ready,
  output logic [TL_OPW-1:0]   in_d_opcode,
  output logic [TL_DPARW-1:0] in_d_param,
  output logic [TL_SZW-1:0]   in_d_size,
  output logic [TL_SRCW-1:0]  in_d_source,
  output logic [TL_SINKW-1:0] in_d_sink,
  output logic                in_d_denied,
  output logic [TL_DW-1:0]    in_d_data,
  output logic                in_d_corrupt,

  output logic                idle
);

  tl_a_t w_a_enq;
  tl_a_t w_a_deq;
  tl_d_t w_d_enq;
  tl_d_t w_d_deq;
  logic  w_a_empty;
  logic  w_d_empty;

  assign w_a_enq.opcode  = in_a_opcode;
  assign w_a_enq.param   = in_a_param;
  assign w_a_enq.size    = in_a_size;
  assign w_a_enq.source  = in_a_source;
  assign w_a_enq.address = in_a_address;
  assign w_a_enq.mask    = in_a_mask;
  assign w_a_enq.data    = in_a_data;
  assign w_a_enq.corrupt = in_a_corrupt;

  assign out_a_opcode  = w_a_deq.opcode;
  assign out_a_param   = w_a_deq.param;
  assign out_a_size    = w_a_deq.size;
  assign out_a_source  = w_a_deq.source;
  assign out_a_address = w_a_deq.address;
  assign out_a_mask    = w_a_deq.mask;
  assign out_a_data    = w_a_deq.data;
  assign out_a_corrupt = w_a_deq.corrupt;

  assign w_d_enq.opcode  = out_d_opcode;
  assign w_d_enq.param   = out_d_param;
  assign w_d_enq.size    = out_d_size;
  assign w_d_enq.source  = out_d_source;
  assign w_d_enq.sink    = out_d_sink;
  assign w_d_enq.denied  = out_d_denied;
  assign w_d_enq.data    = out_d_data;
  assign w_d_enq.corrupt = out_d_corrupt;

  assign in_d_opcode  = w_d_deq.opcode;
  assign in_d_param   = w_d_deq.param;
  assign in_d_size    = w_d_deq.size;
  assign in_d_source  = w_d_deq.source;
  assign in_d_sink    = w_d_deq.sink;
  assign in_d_denied  = w_d_deq.denied;
  assign in_d_data    = w_d_deq.data;
  assign in_d_corrupt = w_d_deq.corrupt;

  tl_ul_fifo #(
    .DEPTH (A_DEPTH),
    .WIDTH ($bits(tl_a_t))
  ) u_a_fifo (
    .i_clock     (clock),
    .i_rst_n     (reset),
    .i_enq_valid (in_a_valid),
    .o_enq_ready (in_a_ready),
    .i_enq_data  (w_a_enq),
    .o_deq_valid (out_a_valid),
    .i_deq_ready (out_a_ready),
    .o_deq_data  (w_a_deq),
    .o_empty     (w_a_empty)
  );

  tl_ul_fifo #(
    .DEPTH (D_DEPTH),
    .WIDTH ($bits(tl_d_t))
  ) u_d_fifo (
    .i_clock     (clock),
    .i_rst_n     (reset),
    .i_enq_valid (out_d_valid),
    .o_enq_ready (out_d_ready),
    .i_enq_data  (w_d_enq),
    .o_deq_valid (in_d_valid),
    .i_deq_ready (in_d_ready),
    .o_deq_data  (w_d_deq),
    .o_empty     (w_d_empty)
  );

  assign idle = w_a_empty & w_d_empty;

endmodule

// File: tb/tb_tl_ul_channel_buffer.sv
module tb_tl_ul_channel_buffer;
  import tl_ul_pkg::*;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  logic        in_a_valid = 1'b0, in_a_ready;
  logic [2:0]  in_a_opcode = 3'd0, in_a_param = 3'd0, in_a_size = 3'd0;
  logic [6:0]  in_a_source = 7'd0;
  logic [29:0] in_a_address = 30'd0;
  logic [3:0]  in_a_mask = 4'd0;
  logic [31:0] in_a_data = 32'd0;
  logic        in_a_corrupt = 1'b0;
  logic        out_a_valid, out_a_ready = 1'b0;
  logic [2:0]  out_a_opcode, out_a_param, out_a_size;
  logic [6:0]  out_a_source;
  logic [29:0] out_a_address;
  logic [3:0]  out_a_mask;
  logic [31:0] out_a_data;
  logic        out_a_corrupt;
  logic        out_d_valid = 1'b0, out_d_ready;
  logic [2:0]  out_d_opcode = 3'd0, out_d_size = 3'd0;
  logic [1:0]  out_d_param = 2'd0;
  logic [6:0]  out_d_source = 7'd0;
  logic [0:0]  out_d_sink = 1'b0;
  logic        out_d_denied = 1'b0;
  logic [31:0] out_d_data = 32'd0;
  logic        out_d_corrupt = 1'b0;
  logic        in_d_valid, in_d_ready = 1'b0;
  logic [2:0]  in_d_opcode, in_d_size;
  logic [1:0]  in_d_param;
  logic [6:0]  in_d_source;
  logic [0:0]  in_d_sink;
  logic        in_d_denied;
  logic [31:0] in_d_data;
  logic        in_d_corrupt;
  logic        idle;

  tl_ul_channel_buffer dut (
    .clock(clock), .reset(rst_n),
    .in_a_valid(in_a_valid), .in_a_ready(in_a_ready), .in_a_opcode(in_a_opcode),
    .in_a_param(in_a_param), .in_a_size(in_a_size), .in_a_source(in_a_source),
    .in_a_address(in_a_address), .in_a_mask(in_a_mask), .in_a_data(in_a_data),
    .in_a_corrupt(in_a_corrupt),
    .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_opcode(out_a_opcode),
    .out_a_param(out_a_param), .out_a_size(out_a_size), .out_a_source(out_a_source),
    .out_a_address(out_a_address), .out_a_mask(out_a_mask), .out_a_data(out_a_data),
    .out_a_corrupt(out_a_corrupt),
    .out_d_valid(out_d_valid), .out_d_ready(out_d_ready), .out_d_opcode(out_d_opcode),
    .out_d_param(out_d_param), .out_d_size(out_d_size), .out_d_source(out_d_source),
    .out_d_sink(out_d_sink), .out_d_denied(out_d_denied), .out_d_data(out_d_data),
    .out_d_corrupt(out_d_corrupt),
    .in_d_valid(in_d_valid), .in_d_ready(in_d_ready), .in_d_opcode(in_d_opcode),
    .in_d_param(in_d_param), .in_d_size(in_d_size), .in_d_source(in_d_source),
    .in_d_sink(in_d_sink), .in_d_denied(in_d_denied), .in_d_data(in_d_data),
    .in_d_corrupt(in_d_corrupt),
    .idle(idle)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int a_pops   = 0;
  int d_pops   = 0;
  tl_a_t exp_a[$];
  tl_d_t exp_d[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: sample mid-cycle, pop/compare on output handshakes,
  // check stall stability, then record accepted input beats.
  bit    a_stall = 1'b0, d_stall = 1'b0;
  tl_a_t prev_a, cur_a, in_a_beat, e_a;
  tl_d_t prev_d, cur_d, in_d_beat, e_d;
  always @(negedge clock) begin
    if (!rst_n) begin
      a_stall = 1'b0;
      d_stall = 1'b0;
    end else begin
      cur_a = '{opcode:out_a_opcode, param:out_a_param, size:out_a_size, source:out_a_source,
                address:out_a_address, mask:out_a_mask, data:out_a_data, corrupt:out_a_corrupt};
      cur_d = '{opcode:in_d_opcode, param:in_d_param, size:in_d_size, source:in_d_source,
                sink:in_d_sink, denied:in_d_denied, data:in_d_data, corrupt:in_d_corrupt};
      if (a_stall) begin
        chk("a_hold_valid", 128'(out_a_valid), 128'(1));
        chk("a_hold_payload", 128'(cur_a), 128'(prev_a));
      end
      if (d_stall) begin
        chk("d_hold_valid", 128'(in_d_valid), 128'(1));
        chk("d_hold_payload", 128'(cur_d), 128'(prev_d));
      end
      if (out_a_valid && out_a_ready) begin
        chk("a_expected_beat", 128'(exp_a.size() != 0), 128'(1));
        if (exp_a.size() != 0) begin
          e_a = exp_a.pop_front();
          chk("a_payload", 128'(cur_a), 128'(e_a));
          a_pops++;
        end
      end
      if (in_d_valid && in_d_ready) begin
        chk("d_expected_beat", 128'(exp_d.size() != 0), 128'(1));
        if (exp_d.size() != 0) begin
          e_d = exp_d.pop_front();
          chk("d_payload", 128'(cur_d), 128'(e_d));
          d_pops++;
        end
      end
      a_stall = out_a_valid && !out_a_ready;
      d_stall = in_d_valid && !in_d_ready;
      prev_a  = cur_a;
      prev_d  = cur_d;
      if (in_a_valid && in_a_ready) begin
        in_a_beat = '{opcode:in_a_opcode, param:in_a_param, size:in_a_size, source:in_a_source,
                      address:in_a_address, mask:in_a_mask, data:in_a_data, corrupt:in_a_corrupt};
        exp_a.push_back(in_a_beat);
      end
      if (out_d_valid && out_d_ready) begin
        in_d_beat = '{opcode:out_d_opcode, param:out_d_param, size:out_d_size, source:out_d_source,
                      sink:out_d_sink, denied:out_d_denied, data:out_d_data, corrupt:out_d_corrupt};
        exp_d.push_back(in_d_beat);
      end
    end
  end

  // Caller is at posedge+1; returns at posedge+1 after the handshake edge.
  task automatic send_a(input tl_a_t p, output int waited);
    waited = 0;
    in_a_valid = 1'b1;
    {in_a_opcode, in_a_param, in_a_size, in_a_source, in_a_address, in_a_mask,
     in_a_data, in_a_corrupt} = p;
    @(negedge clock);
    while (!in_a_ready && waited < 500) begin
      waited++;
      @(negedge clock);
    end
    if (!in_a_ready) chk("a_send_ready", 128'(in_a_ready), 128'(1));
    @(posedge clock); #1;
    in_a_valid = 1'b0;
  endtask

  task automatic send_d(input tl_d_t p, output int waited);
    waited = 0;
    out_d_valid = 1'b1;
    {out_d_opcode, out_d_param, out_d_size, out_d_source, out_d_sink, out_d_denied,
     out_d_data, out_d_corrupt} = p;
    @(negedge clock);
    while (!out_d_ready && waited < 500) begin
      waited++;
      @(negedge clock);
    end
    if (!out_d_ready) chk("d_send_ready", 128'(out_d_ready), 128'(1));
    @(posedge clock); #1;
    out_d_valid = 1'b0;
  endtask

  task automatic step;
    @(posedge clock); #1;
  endtask

  tl_a_t pa;
  tl_d_t pd;
  int    w, total_w, base;

  initial begin
    // Power-on reset state
    repeat (2) @(negedge clock);
    chk("rst_in_a_ready", 128'(in_a_ready), 128'(0));
    chk("rst_out_d_ready", 128'(out_d_ready), 128'(0));
    chk("rst_out_a_valid", 128'(out_a_valid), 128'(0));
    chk("rst_in_d_valid", 128'(in_d_valid), 128'(0));
    chk("rst_idle", 128'(idle), 128'(1));
    step();
    rst_n = 1'b1;
    @(negedge clock);
    chk("post_rst_in_a_ready", 128'(in_a_ready), 128'(1));
    chk("post_rst_out_d_ready", 128'(out_d_ready), 128'(1));

    // Reset mid-traffic: two beats buffered, then discarded
    step();
    pa = '{opcode:PutFull, param:3'd0, size:3'd2, source:7'h01, address:30'h100,
           mask:4'hF, data:32'h11, corrupt:1'b0};
    send_a(pa, w);
    pa.data = 32'h22;
    send_a(pa, w);
    rst_n = 1'b0;
    exp_a.delete();
    repeat (3) begin
      @(negedge clock);
      chk("midrst_out_a_valid", 128'(out_a_valid), 128'(0));
      chk("midrst_in_a_ready", 128'(in_a_ready), 128'(0));
      chk("midrst_idle", 128'(idle), 128'(1));
      step();
    end
    rst_n = 1'b1;
    out_a_ready = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("relrst_in_a_ready", 128'(in_a_ready), 128'(1));
      chk("relrst_idle", 128'(idle), 128'(1));
      chk("relrst_no_stale", 128'(out_a_valid), 128'(0));
      step();
    end

    // Single Get with one-cycle latency, held until the adapter accepts
    out_a_ready = 1'b0;
    in_a_valid = 1'b1;
    in_a_opcode = Get; in_a_param = 3'd0; in_a_size = 3'd2; in_a_source = 7'h15;
    in_a_address = 30'h0000_1F00; in_a_mask = 4'hF; in_a_data = 32'h0; in_a_corrupt = 1'b0;
    @(negedge clock);
    chk("get_accept", 128'(in_a_ready), 128'(1));
    chk("get_no_flowthrough", 128'(out_a_valid), 128'(0));
    chk("get_idle_before", 128'(idle), 128'(1));
    step();
    in_a_valid = 1'b0;
    @(negedge clock);
    chk("get_out_valid", 128'(out_a_valid), 128'(1));
    chk("get_idle_busy", 128'(idle), 128'(0));
    step();
    out_a_ready = 1'b1;
    @(negedge clock);
    chk("get_idle_until_deq", 128'(idle), 128'(0));
    step();
    @(negedge clock);
    chk("get_idle_after", 128'(idle), 128'(1));
    chk("get_out_empty", 128'(out_a_valid), 128'(0));
    step();

    // Backpressure and full
    out_a_ready = 1'b0;
    pa = '{opcode:PutFull, param:3'd0, size:3'd2, source:7'h02, address:30'h200,
           mask:4'hF, data:32'hA0, corrupt:1'b0};
    send_a(pa, w);
    chk("bp_a0_wait", 128'(w), 128'(0));
    pa.data = 32'hA1;
    send_a(pa, w);
    chk("bp_a1_wait", 128'(w), 128'(0));
    in_a_valid = 1'b1;
    in_a_data  = 32'hA2;
    @(negedge clock);
    chk("bp_full_ready", 128'(in_a_ready), 128'(0));
    step();
    out_a_ready = 1'b1;
    @(negedge clock);
    chk("bp_deq_cycle_ready", 128'(in_a_ready), 128'(0));
    step();
    @(negedge clock);
    chk("bp_next_cycle_ready", 128'(in_a_ready), 128'(1));
    step();
    in_a_valid = 1'b0;
    repeat (3) step();

    // Streaming: 100 back-to-back PutFull beats
    base = a_pops;
    total_w = 0;
    for (int i = 0; i < 100; i++) begin
      pa = '{opcode:PutFull, param:3'd0, size:3'd2, source:7'(i), address:30'(i * 4),
             mask:4'hF, data:32'(i), corrupt:1'b0};
      send_a(pa, w);
      total_w += w;
    end
    chk("stream_no_stall", 128'(total_w), 128'(0));
    @(negedge clock);
    chk("stream_last_out", 128'(out_a_valid), 128'(1));
    step();
    @(negedge clock);
    chk("stream_count", 128'(a_pops - base), 128'(100));
    step();

    // D path with error flags and a toggling master ready
    base = d_pops;
    fork
      begin
        pd = '{opcode:AccessAckData, param:2'd0, size:3'd2, source:7'h7F, sink:1'b1,
               denied:1'b1, data:32'hDEADBEEF, corrupt:1'b1};
        send_d(pd, w);
        pd = '{opcode:AccessAck, param:2'd1, size:3'd2, source:7'h01, sink:1'b0,
               denied:1'b0, data:32'h0, corrupt:1'b0};
        send_d(pd, w);
        pd = '{opcode:AccessAckData, param:2'd0, size:3'd2, source:7'h2A, sink:1'b0,
               denied:1'b0, data:32'h12345678, corrupt:1'b0};
        send_d(pd, w);
      end
      begin
        for (int c = 0; c < 16; c++) begin
          in_d_ready = c[0];
          step();
        end
      end
    join
    in_d_ready = 1'b1;
    repeat (2) step();
    chk("d_count", 128'(d_pops - base), 128'(3));

    // Random valid/ready traffic on both channels
    fork
      begin
        for (int k = 0; k < 150; k++) begin
          repeat ($urandom_range(0, 1)) step();
          pa = '{opcode:3'($urandom_range(0, 7)), param:3'($urandom_range(0, 7)),
                 size:3'($urandom_range(0, 7)), source:7'($urandom), address:30'($urandom),
                 mask:4'($urandom), data:$urandom, corrupt:1'($urandom)};
          send_a(pa, w);
        end
      end
      begin
        for (int k = 0; k < 150; k++) begin
          repeat ($urandom_range(0, 1)) step();
          pd = '{opcode:3'($urandom_range(0, 7)), param:2'($urandom), size:3'($urandom),
                 source:7'($urandom), sink:1'($urandom), denied:1'($urandom),
                 data:$urandom, corrupt:1'($urandom)};
          send_d(pd, w);
        end
      end
      begin
        for (int c = 0; c < 1200; c++) begin
          out_a_ready = 1'($urandom_range(0, 1));
          in_d_ready  = 1'($urandom_range(0, 1));
          step();
        end
        out_a_ready = 1'b1;
        in_d_ready  = 1'b1;
      end
    join

    // Drain and final state
    for (int c = 0; c < 100 && (exp_a.size() != 0 || exp_d.size() != 0); c++) step();
    @(negedge clock);
    chk("drain_a_empty", 128'(exp_a.size()), 128'(0));
    chk("drain_d_empty", 128'(exp_d.size()), 128'(0));
    chk("final_idle", 128'(idle), 128'(1));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
